// File: rtl/line_beat_buffer.sv
// Line fill / writeback beat engine between a 128-bit cache line port and a 16-bit memory port.
// Optional critical-word-first fills: define LINE_BEAT_CRIT_FIRST_EN.
//
// state | meaning
// IDLE  | waiting for line_read / line_write
// FILL  | collecting eight read beats into the assembly register
// WB    | issuing eight write beats from the captured line
// DONE  | one-cycle line_resp, then back to IDLE
module line_beat_buffer #(
  parameter int WORDS  = 8,
  parameter int ADDR_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  line_read,
  input  logic                  line_write,
  input  logic [ADDR_W-1:0]     line_addr,
  input  logic [2:0]            word_offset,
  input  logic [WORDS*16-1:0]   wb_data,
  output logic [WORDS*16-1:0]   line_rdata,
  output logic                  line_resp,
  output logic                  busy,
  output logic [15:0]           crit_word,
  output logic                  crit_valid,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [15:0]           mem_wdata,
  output logic [1:0]            mem_byte_enable,
  input  logic [15:0]           mem_rdata,
  input  logic                  mem_resp
);

  typedef enum logic [1:0] {IDLE, FILL, WB, DONE} state_t;

  state_t                    state_q, state_d;
  logic [2:0]                beat_q, beat_d;
  logic [2:0]                remain_q, remain_d;
  logic [ADDR_W-5:0]         base_q, base_d;
  logic [WORDS-1:0][15:0]    wb_line_q, wb_line_d;
  logic [WORDS-1:0][15:0]    asm_q, asm_d;
  logic [WORDS-1:0][15:0]    rdata_q, rdata_d;
  logic [2:0]                start_beat;

`ifdef LINE_BEAT_CRIT_FIRST_EN
  logic        crit_valid_q, crit_valid_d;
  logic [15:0] crit_word_q, crit_word_d;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^line_addr[3:0];
  assign start_beat       = word_offset;
`else
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{line_addr[3:0], word_offset};
  assign start_beat       = 3'd0;
`endif

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    remain_d  = remain_q;
    base_d    = base_q;
    wb_line_d = wb_line_q;
    asm_d     = asm_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (line_write) begin
          state_d   = WB;
          base_d    = line_addr[ADDR_W-1:4];
          wb_line_d = wb_data;
          beat_d    = 3'd0;
          remain_d  = 3'd7;
        end else if (line_read) begin
          state_d  = FILL;
          base_d   = line_addr[ADDR_W-1:4];
          beat_d   = start_beat;
          remain_d = 3'd7;
        end
      end
      FILL: begin
        if (mem_resp) begin
          asm_d[beat_q] = mem_rdata;
          beat_d        = beat_q + 3'd1;
          remain_d      = remain_q - 3'd1;
          // Publish the line on the final beat's edge, including that beat.
          if (remain_q == 3'd0) begin
            state_d = DONE;
            rdata_d = asm_d;
          end
        end
      end
      WB: begin
        if (mem_resp) begin
          beat_d   = beat_q + 3'd1;
          remain_d = remain_q - 3'd1;
          if (remain_q == 3'd0) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      beat_q    <= 3'd0;
      remain_q  <= 3'd0;
      base_q    <= '0;
      wb_line_q <= '0;
      asm_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      remain_q  <= remain_d;
      base_q    <= base_d;
      wb_line_q <= wb_line_d;
      asm_q     <= asm_d;
      rdata_q   <= rdata_d;
    end
  end

`ifdef LINE_BEAT_CRIT_FIRST_EN
  // First beat of a fill is the one seen while the down-counter is still full.
  always_comb begin
    crit_valid_d = (state_q == FILL) && mem_resp && (remain_q == 3'd7);
    crit_word_d  = crit_valid_d ? mem_rdata : crit_word_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crit_valid_q <= 1'b0;
      crit_word_q  <= '0;
    end else begin
      crit_valid_q <= crit_valid_d;
      crit_word_q  <= crit_word_d;
    end
  end

  assign crit_valid = crit_valid_q;
  assign crit_word  = crit_word_q;
`else
  assign crit_valid = 1'b0;
  assign crit_word  = '0;
`endif

  assign line_rdata      = rdata_q;
  assign line_resp       = (state_q == DONE);
  assign busy            = (state_q != IDLE);
  assign mem_read        = (state_q == FILL);
  assign mem_write       = (state_q == WB);
  assign mem_address     = {base_q, beat_q, 1'b0};
  assign mem_wdata       = (state_q == WB) ? wb_line_q[beat_q] : 16'h0000;
  assign mem_byte_enable = (state_q == WB) ? 2'b11 : 2'b00;

endmodule

// File: tb/tb_line_beat_buffer.sv
// Randomized bench for line_beat_buffer against a transaction-level model of fills and writebacks.
module tb_line_beat_buffer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         line_read, line_write;
  logic [15:0]  line_addr;
  logic [2:0]   word_offset;
  logic [127:0] wb_data;
  logic [127:0] line_rdata;
  logic         line_resp, busy, crit_valid, mem_read, mem_write, mem_resp;
  logic [15:0]  crit_word, mem_address, mem_wdata, mem_rdata;
  logic [1:0]   mem_byte_enable;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [127:0] prev_rdata = '0;

  always #5 clk = ~clk;

  line_beat_buffer #(.WORDS(8), .ADDR_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .line_read(line_read), .line_write(line_write), .line_addr(line_addr),
    .word_offset(word_offset), .wb_data(wb_data), .line_rdata(line_rdata),
    .line_resp(line_resp), .busy(busy), .crit_word(crit_word), .crit_valid(crit_valid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int fill_start(input logic [2:0] off);
`ifdef LINE_BEAT_CRIT_FIRST_EN
    return int'(off);
`else
    return 0;
`endif
  endfunction

  // waits < 0 picks a random 0..3 wait count before each beat.
  task automatic run_txn(input bit wr, input bit rd, input logic [15:0] addr, input logic [2:0] off,
                         input logic [127:0] wbd, input int waits, input bit keep_rd, input bit resp_in_done);
    logic [127:0] exp_line;
    logic [15:0]  first_data, crit_seen;
    logic [2:0]   b3;
    int           k, w, cyc, total_wait, bidx, start, crit_pulses;
    bit           is_wb;
    is_wb       = wr;
    start       = is_wb ? 0 : fill_start(off);
    exp_line    = prev_rdata;
    first_data  = '0;
    crit_seen   = '0;
    crit_pulses = 0;
    @(negedge clk);
    check_val("idle_busy", 128'(busy), 128'(0));
    line_write  = wr;
    line_read   = rd;
    line_addr   = addr;
    word_offset = off;
    wb_data     = wbd;
    @(posedge clk);
    #1;
    line_addr   = 16'($urandom);
    word_offset = 3'($urandom);
    wb_data     = {$urandom, $urandom, $urandom, $urandom};
    k = 0; cyc = 0; total_wait = 0;
    w = (waits < 0) ? int'($urandom_range(0, 3)) : waits;
    while (k < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (crit_valid) begin crit_pulses++; crit_seen = crit_word; end
      bidx = (start + k) % 8;
      b3   = 3'(bidx);
      check_val("busy", 128'(busy), 128'(1));
      check_val("mem_read", 128'(mem_read), 128'(!is_wb));
      check_val("mem_write", 128'(mem_write), 128'(is_wb));
      check_val("mem_address", 128'(mem_address), 128'({addr[15:4], b3, 1'b0}));
      check_val("mem_wdata", 128'(mem_wdata), is_wb ? 128'(wbd[bidx*16 +: 16]) : 128'(0));
      check_val("byte_enable", 128'(mem_byte_enable), is_wb ? 128'(3) : 128'(0));
      check_val("early_resp", 128'(line_resp), 128'(0));
      if (w > 0) begin
        mem_resp = 1'b0;
        w--;
        total_wait++;
      end else begin
        mem_resp  = 1'b1;
        mem_rdata = 16'($urandom);
        if (!is_wb) exp_line[bidx*16 +: 16] = mem_rdata;
        if (k == 0) first_data = mem_rdata;
        k++;
        w = (waits < 0) ? int'($urandom_range(0, 3)) : waits;
      end
      @(posedge clk);
    end
    if (k < 8) check_val("beat_timeout", 128'(k), 128'(8));
    @(negedge clk);
    cyc++;
    if (crit_valid) begin crit_pulses++; crit_seen = crit_word; end
    check_val("resp_cycle", 128'(cyc), 128'(9 + total_wait));
    check_val("line_resp", 128'(line_resp), 128'(1));
    check_val("done_busy", 128'(busy), 128'(1));
    check_val("done_strobes", 128'({mem_read, mem_write, mem_byte_enable}), 128'(0));
    check_val(is_wb ? "wb_rdata_held" : "fill_line", line_rdata, exp_line);
    prev_rdata = exp_line;
`ifdef LINE_BEAT_CRIT_FIRST_EN
    check_val("crit_pulses", 128'(crit_pulses), is_wb ? 128'(0) : 128'(1));
    if (!is_wb) check_val("crit_word", 128'(crit_seen), 128'(first_data));
`else
    check_val("crit_pulses", 128'(crit_pulses), 128'(0));
    check_val("crit_word_tied", 128'(crit_word), 128'(0));
`endif
    mem_resp  = resp_in_done;
    mem_rdata = 16'($urandom);
    line_write = 1'b0;
    if (!keep_rd) line_read = 1'b0;
    @(posedge clk);
    #1 mem_resp = 1'b0;
  endtask

  task automatic idle_noise(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_val("idle_busy_n", 128'(busy), 128'(0));
      check_val("idle_strobes", 128'({mem_read, mem_write, mem_byte_enable, line_resp}), 128'(0));
      check_val("idle_rdata", line_rdata, prev_rdata);
      mem_resp  = 1'($urandom);
      mem_rdata = 16'($urandom);
      @(posedge clk);
    end
    #1 mem_resp = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val(tag, {line_rdata}, 128'(0));
    check_val(tag, 128'({line_resp, busy, crit_word, crit_valid, mem_read, mem_write,
                         mem_address, mem_wdata, mem_byte_enable}), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit wr, rd;
    reset_n = 1'b0; line_read = 1'b0; line_write = 1'b0; line_addr = '0;
    word_offset = '0; wb_data = '0; mem_rdata = '0; mem_resp = 1'b0;
    #1 check_all_zero("reset_outputs");
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    run_txn(1'b0, 1'b1, 16'h1230, 3'd0, '0, 0, 1'b0, 1'b0);
    run_txn(1'b1, 1'b0, 16'h2340, 3'd0, 128'h7777_6666_5555_4444_3333_2222_1111_0000, 2, 1'b0, 1'b0);
    run_txn(1'b1, 1'b1, 16'h4000, 3'd3, {4{$urandom}}, -1, 1'b1, 1'b1);
    run_txn(1'b0, 1'b1, 16'h4000, 3'd3, '0, -1, 1'b0, 1'b1);
    idle_noise(5);
    run_txn(1'b0, 1'b1, 16'h89A0, 3'd6, '0, -1, 1'b0, 1'b0);

    @(negedge clk);
    line_read = 1'b1; line_addr = 16'h5670; word_offset = 3'd2;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_resp = 1'b1; mem_rdata = 16'($urandom);
      @(posedge clk);
    end
    @(negedge clk);
    mem_resp = 1'b1; mem_rdata = 16'hBEEF;
    #2 reset_n = 1'b0;
    #1 check_all_zero("reset_mid_fill");
    line_read = 1'b0; mem_resp = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("reset_no_resp", 128'({line_resp, busy}), 128'(0));
    reset_n = 1'b1;
    prev_rdata = '0;
    run_txn(1'b0, 1'b1, 16'h5670, 3'd2, '0, -1, 1'b0, 1'b0);

    for (int t = 0; t < 10; t++) begin
      wr = 1'($urandom);
      rd = wr ? 1'($urandom) : 1'b1;
      run_txn(wr, rd, 16'($urandom), 3'($urandom), {$urandom, $urandom, $urandom, $urandom},
              ($urandom_range(0, 1) == 0) ? 0 : -1, 1'b0, 1'($urandom));
      idle_noise(2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
